mag_energy_trigger: RTL



---
 rtl/mag_energy_trigger.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mag_energy_trigger.sv
// mag_energy_trigger: sliding-window magnitude average with hysteresis/debounce energy trigger.
// Define MAG_TRIG_PEAK_EN to add the peak_mag output (peak average seen during a trigger).
module mag_energy_trigger #(
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LOG2   = 4,
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] mag,
  input  logic                  mag_stb,
  input  logic [DATA_WIDTH-1:0] threshold_high,
  input  logic [DATA_WIDTH-1:0] threshold_low,
  input  logic [HOLD_WIDTH-1:0] assert_count,
  input  logic [HOLD_WIDTH-1:0] release_count,
  output logic [DATA_WIDTH-1:0] avg_mag,
  output logic                  avg_stb,
  output logic                  power_trig,
  output logic                  trig_start,
  output logic                  trig_end
`ifdef MAG_TRIG_PEAK_EN
  ,
  output logic [DATA_WIDTH-1:0] peak_mag
`endif
);
  localparam int N  = 1 << WIN_LOG2;
  localparam int SW = DATA_WIDTH + WIN_LOG2;
  localparam logic [HOLD_WIDTH-1:0] cnt_one = HOLD_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, ARMING, ACTIVE, RELEASING} state_t;
  logic [DATA_WIDTH-1:0] win_q [N];
  logic [WIN_LOG2-1:0]   wptr_q;
  logic [WIN_LOG2:0]     fill_q;
  logic [SW-1:0]         sum_q;
  logic                  pend_q;
  logic [DATA_WIDTH-1:0] avg_q;
  logic                  avg_stb_q;
  state_t                state_q, state_d;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  start_q, start_d, end_q, end_d, power_trig_q;
  logic                  accept, full, eval, hi, lo;
  logic [DATA_WIDTH-1:0] oldest;
  logic [HOLD_WIDTH-1:0] ac, rc, cnt_inc;
  assign accept  = enable && mag_stb;
  assign full    = fill_q[WIN_LOG2];
  assign oldest  = full ? win_q[wptr_q] : '0;
  assign eval    = enable && avg_stb_q;
  assign hi      = avg_q >= threshold_high;
  assign lo      = avg_q < threshold_low;
  assign ac      = (assert_count == '0) ? cnt_one : assert_count;
  assign rc      = (release_count == '0) ? cnt_one : release_count;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + cnt_one;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    if (eval) begin
      case (state_q)
        IDLE: begin
          cnt_d   = hi ? cnt_one : '0;
          start_d = hi && ac == cnt_one;
          state_d = !hi ? IDLE : start_d ? ACTIVE : ARMING;
        end
        ARMING: begin
          cnt_d   = hi ? cnt_inc : '0;
          start_d = hi && cnt_inc >= ac;
          state_d = !hi ? IDLE : start_d ? ACTIVE : ARMING;
        end
        ACTIVE: begin
          cnt_d   = lo ? cnt_one : cnt_q;
          end_d   = lo && rc == cnt_one;
          state_d = !lo ? ACTIVE : end_d ? IDLE : RELEASING;
        end
        RELEASING: begin
          cnt_d   = lo ? cnt_inc : cnt_q;
          end_d   = lo && cnt_inc >= rc;
          state_d = !lo ? ACTIVE : end_d ? IDLE : RELEASING;
        end
      endcase
    end
  end
  // Window storage is deliberately left out of reset; the fill counter masks stale entries.
  always_ff @(posedge clock) begin
    if (accept) win_q[wptr_q] <= mag;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      fill_q       <= '0;
      sum_q        <= '0;
      pend_q       <= 1'b0;
      avg_q        <= '0;
      avg_stb_q    <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      end_q        <= 1'b0;
      power_trig_q <= 1'b0;
`ifdef MAG_TRIG_PEAK_EN
      peak_mag     <= '0;
`endif
    end else if (enable) begin
      if (accept) begin
        wptr_q <= wptr_q + WIN_LOG2'(1);
        fill_q <= full ? fill_q : fill_q + (WIN_LOG2 + 1)'(1);
        sum_q  <= sum_q + SW'(mag) - SW'(oldest);
      end
      pend_q       <= accept && (full || fill_q == (WIN_LOG2 + 1)'(N - 1));
      avg_stb_q    <= pend_q;
      avg_q        <= pend_q ? sum_q[SW-1:WIN_LOG2] : avg_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      end_q        <= end_d;
      power_trig_q <= state_d == ACTIVE || state_d == RELEASING;
`ifdef MAG_TRIG_PEAK_EN
      if (start_d) peak_mag <= avg_q;
      else if (eval && power_trig_q && avg_q > peak_mag) peak_mag <= avg_q;
`endif
    end else begin
      avg_stb_q <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
    end
  end
  assign avg_mag    = avg_q;
  assign avg_stb    = avg_stb_q;
  assign power_trig = power_trig_q;
  assign trig_start = start_q;
  assign trig_end   = end_q;
endmodule
